// File: rtl/noc_pkg.sv
// Shared definitions for the NoC network interface slice.
package noc_pkg;

    localparam int FLIT_W = 20;
    localparam int POS_W  = 4;
    localparam int STAT_W = 16;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used for both NI directions.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module noc_sync_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/noc_network_interface.sv
// Network interface between a PE and a router local port: inject FIFO with
// downstream credit tracking, eject FIFO with credit return.
// Optional build macro NI_STATS_EN enables 16-bit inject/eject flit counters;
// without it inj_count/ej_count are tied to zero.
module noc_network_interface
    import noc_pkg::*;
#(
    parameter int FLIT_W         = noc_pkg::FLIT_W,
    parameter int INJ_DEPTH      = 4,
    parameter int EJ_DEPTH       = 4,
    parameter int ROUTER_CREDITS = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [FLIT_W-1:0] pe_tx_data,
    input  logic              pe_tx_valid,
    output logic              pe_tx_ready,
    output logic [FLIT_W-1:0] pe_rx_data,
    output logic              pe_rx_valid,
    input  logic              pe_rx_ready,
    output logic [FLIT_W-1:0] inj_data,
    output logic              inj_valid,
    input  logic              inj_credit,
    input  logic [FLIT_W-1:0] ej_data,
    input  logic              ej_valid,
    output logic              ej_credit,
    output logic              err,
    output logic [15:0]       inj_count,
    output logic [15:0]       ej_count
);

    localparam int                CRED_W   = clog2(ROUTER_CREDITS + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(ROUTER_CREDITS);

    logic              inj_full;
    logic              inj_empty;
    logic [FLIT_W-1:0] inj_head;
    logic              ej_full;
    logic              ej_empty;
    logic              pe_push;
    logic              issue;
    logic              ej_pop;
    logic              credit_overflow;
    logic              ej_drop;

    logic [CRED_W-1:0] credit;
    logic [FLIT_W-1:0] inj_data_p1;
    logic              inj_vld_p1;
    logic              ej_credit_p1;
    logic              err_q;

    assign pe_tx_ready     = !inj_full;
    assign pe_push         = pe_tx_valid && pe_tx_ready;
    assign issue           = !inj_empty && (credit != '0);
    assign pe_rx_valid     = !ej_empty;
    assign ej_pop          = pe_rx_valid && pe_rx_ready;
    assign credit_overflow = inj_credit && !issue && (credit == CRED_MAX);
    assign ej_drop         = ej_valid && ej_full && !ej_pop;

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk   (clk),
        .rst_n (RST),
        .push  (pe_push),
        .din   (pe_tx_data),
        .pop   (issue),
        .dout  (inj_head),
        .full  (inj_full),
        .empty (inj_empty)
    );

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk   (clk),
        .rst_n (RST),
        .push  (ej_valid),
        .din   (ej_data),
        .pop   (ej_pop),
        .dout  (pe_rx_data),
        .full  (ej_full),
        .empty (ej_empty)
    );

    // Downstream credit counter: issue consumes, router pulse returns; overflow pulses are ignored.
    always_ff @(posedge clk) begin
        if (!RST) begin
            credit <= CRED_MAX;
        end else if (issue && !inj_credit) begin
            credit <= credit - CRED_W'(1);
        end else if (!issue && inj_credit && (credit != CRED_MAX)) begin
            credit <= credit + CRED_W'(1);
        end
    end

    // Issue stage: popped flit is registered and strobed to the router for one cycle.
    always_ff @(posedge clk) begin
        if (!RST) begin
            inj_vld_p1  <= 1'b0;
            inj_data_p1 <= '0;
        end else begin
            inj_vld_p1 <= issue;
            if (issue) inj_data_p1 <= inj_head;
        end
    end

    // Credit-return stage: one registered pulse per PE pop.
    always_ff @(posedge clk) begin
        if (!RST) ej_credit_p1 <= 1'b0;
        else      ej_credit_p1 <= ej_pop;
    end

    // Sticky protocol error: credit overflow or eject overrun.
    always_ff @(posedge clk) begin
        if (!RST) err_q <= 1'b0;
        else      err_q <= err_q | credit_overflow | ej_drop;
    end

    assign inj_data  = inj_data_p1;
    assign inj_valid = inj_vld_p1;
    assign ej_credit = ej_credit_p1;
    assign err       = err_q;

`ifdef NI_STATS_EN
    logic [STAT_W-1:0] inj_cnt_q;
    logic [STAT_W-1:0] ej_cnt_q;

    // Free-running wrap-around flit counters.
    always_ff @(posedge clk) begin
        if (!RST) begin
            inj_cnt_q <= '0;
            ej_cnt_q  <= '0;
        end else begin
            if (inj_vld_p1) inj_cnt_q <= inj_cnt_q + 1'b1;
            if (ej_pop)     ej_cnt_q  <= ej_cnt_q + 1'b1;
        end
    end

    assign inj_count = inj_cnt_q;
    assign ej_count  = ej_cnt_q;
`else
    assign inj_count = '0;
    assign ej_count  = '0;
`endif

endmodule

// File: tb/tb_noc_network_interface.sv
// Directed bench for noc_network_interface (default and NI_STATS_EN builds).
module tb_noc_network_interface;

    localparam int FW = 20;

    logic          clk = 1'b0;
    logic          RST;
    logic [FW-1:0] pe_tx_data;
    logic          pe_tx_valid;
    logic          pe_tx_ready;
    logic [FW-1:0] pe_rx_data;
    logic          pe_rx_valid;
    logic          pe_rx_ready;
    logic [FW-1:0] inj_data;
    logic          inj_valid;
    logic          inj_credit;
    logic [FW-1:0] ej_data;
    logic          ej_valid;
    logic          ej_credit;
    logic          err;
    logic [15:0]   inj_count;
    logic [15:0]   ej_count;

    logic          inj_credit_drv;
    logic          loopback;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [FW-1:0] inj_q [$];
    int            inj_t [$];
    int            inj_total = 0;
    int            ej_cred_cnt = 0;

    assign inj_credit = loopback ? inj_valid : inj_credit_drv;

    noc_network_interface #(
        .FLIT_W         (FW),
        .INJ_DEPTH      (4),
        .EJ_DEPTH       (4),
        .ROUTER_CREDITS (4)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .pe_tx_data  (pe_tx_data),
        .pe_tx_valid (pe_tx_valid),
        .pe_tx_ready (pe_tx_ready),
        .pe_rx_data  (pe_rx_data),
        .pe_rx_valid (pe_rx_valid),
        .pe_rx_ready (pe_rx_ready),
        .inj_data    (inj_data),
        .inj_valid   (inj_valid),
        .inj_credit  (inj_credit),
        .ej_data     (ej_data),
        .ej_valid    (ej_valid),
        .ej_credit   (ej_credit),
        .err         (err),
        .inj_count   (inj_count),
        .ej_count    (ej_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every injected flit with the cycle it appeared in.
    always @(negedge clk) begin
        if (inj_valid) begin
            inj_q.push_back(inj_data);
            inj_t.push_back(cyc);
            inj_total = inj_total + 1;
        end
        if (ej_credit) ej_cred_cnt = ej_cred_cnt + 1;
    end

`ifndef NI_STATS_EN
    // Counter ports must stay zero for the whole run in the default build.
    always @(negedge clk) begin
        if (RST === 1'b1 && cyc % 16 == 0) begin
            checks = checks + 1;
            if (inj_count !== 16'h0 || ej_count !== 16'h0) begin
                errors = errors + 1;
                $display("FAIL stats_tied_zero inj_count=%0h ej_count=%0h required 0", inj_count, ej_count);
            end
        end
    end
`endif

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; pe_tx_valid = 0; pe_tx_data = '0; pe_rx_ready = 0;
        ej_valid = 0; ej_data = '0; inj_credit_drv = 0; loopback = 0;
        step(2);
        checks++;
        if (inj_valid !== 1'b0 || inj_data !== '0 || ej_credit !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs inj_valid=%b inj_data=%0h ej_credit=%b err=%b required 0", inj_valid, inj_data, ej_credit, err);
        end
        RST = 1'b1;
        step(1);
        checks++;
        if (pe_tx_ready !== 1'b1 || pe_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready pe_tx_ready=%b pe_rx_valid=%b required 1/0", pe_tx_ready, pe_rx_valid);
        end
        checks++;
        if (inj_count !== 16'h0 || ej_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_counts inj_count=%0h ej_count=%0h required 0", inj_count, ej_count);
        end
    endtask

    task automatic test_inject_credits();
        int t0;
        inj_q.delete(); inj_t.delete();
        t0 = cyc;
        for (int i = 1; i <= 5; i++) begin
            pe_tx_valid = 1; pe_tx_data = FW'(i);
            checks++;
            if (pe_tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL inject_ready flit=%0d pe_tx_ready=%b required 1", i, pe_tx_ready);
            end
            step(1);
        end
        pe_tx_valid = 0;
        step(5);
        checks++;
        if (inj_q.size() != 4) begin
            errors++;
            $display("FAIL inject_count issued=%0d required 4", inj_q.size());
        end
        for (int i = 0; i < 4 && i < inj_q.size(); i++) begin
            checks++;
            if (inj_q[i] !== FW'(i + 1) || inj_t[i] != t0 + 2 + i) begin
                errors++;
                $display("FAIL inject_flit idx=%0d data=%0h cycle=%0d required data=%0h cycle=%0d", i, inj_q[i], inj_t[i], i + 1, t0 + 2 + i);
            end
        end
    endtask

    task automatic test_credit_return();
        int c;
        inj_q.delete(); inj_t.delete();
        c = cyc;
        inj_credit_drv = 1;
        step(1);
        inj_credit_drv = 0;
        step(4);
        checks++;
        if (inj_q.size() != 1) begin
            errors++;
            $display("FAIL credit_return issued=%0d required 1", inj_q.size());
        end else begin
            checks++;
            if (inj_q[0] !== 20'h00005 || inj_t[0] != c + 2) begin
                errors++;
                $display("FAIL credit_return_flit data=%0h cycle=%0d required data=5 cycle=%0d", inj_q[0], inj_t[0], c + 2);
            end
        end
    endtask

    task automatic test_credit_same_cycle();
        int c;
        inj_q.delete(); inj_t.delete();
        pe_tx_valid = 1; pe_tx_data = 20'h0000A; step(1);
        pe_tx_data = 20'h0000B; step(1);
        pe_tx_valid = 0;
        step(3);
        checks++;
        if (inj_q.size() != 0) begin
            errors++;
            $display("FAIL no_credit_hold issued=%0d required 0", inj_q.size());
        end
        c = cyc;
        inj_credit_drv = 1;
        step(2);
        inj_credit_drv = 0;
        step(4);
        checks++;
        if (inj_q.size() != 2) begin
            errors++;
            $display("FAIL same_cycle_count issued=%0d required 2", inj_q.size());
        end else begin
            checks++;
            if (inj_q[0] !== 20'h0000A || inj_t[0] != c + 2 || inj_q[1] !== 20'h0000B || inj_t[1] != c + 3) begin
                errors++;
                $display("FAIL same_cycle_flits got %0h@%0d %0h@%0d required a@%0d b@%0d", inj_q[0], inj_t[0], inj_q[1], inj_t[1], c + 2, c + 3);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_err err=%b required 0", err);
        end
    endtask

    task automatic test_eject();
        logic [FW-1:0] exp_flit;
        pe_rx_ready = 0;
        for (int i = 0; i < 4; i++) begin
            ej_valid = 1; ej_data = FW'(32'h100 + i);
            step(1);
        end
        ej_valid = 0;
        checks++;
        if (pe_rx_valid !== 1'b1 || pe_rx_data !== 20'h00100 || err !== 1'b0 || ej_credit !== 1'b0) begin
            errors++;
            $display("FAIL eject_fill valid=%b data=%0h err=%b ej_credit=%b required 1/100/0/0", pe_rx_valid, pe_rx_data, err, ej_credit);
        end
        ej_valid = 1; ej_data = 20'h001FF;
        step(1);
        ej_valid = 0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL eject_overrun_err err=%b required 1", err);
        end
        pe_rx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_flit = FW'(32'h100 + i);
            checks++;
            if (pe_rx_valid !== 1'b1 || pe_rx_data !== exp_flit) begin
                errors++;
                $display("FAIL eject_pop idx=%0d valid=%b data=%0h required 1/%0h", i, pe_rx_valid, pe_rx_data, exp_flit);
            end
            step(1);
            checks++;
            if (ej_credit !== 1'b1) begin
                errors++;
                $display("FAIL eject_credit idx=%0d ej_credit=%b required 1", i, ej_credit);
            end
        end
        checks++;
        if (pe_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL eject_drained pe_rx_valid=%b required 0", pe_rx_valid);
        end
        step(1);
        checks++;
        if (ej_credit !== 1'b0) begin
            errors++;
            $display("FAIL eject_credit_end ej_credit=%b required 0", ej_credit);
        end
        pe_rx_ready = 0;
    endtask

    task automatic test_overflow_and_reset();
        RST = 0; step(1); RST = 1; step(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_err err=%b required 0", err);
        end
        inj_credit_drv = 1; step(1); inj_credit_drv = 0; step(1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL credit_overflow_err err=%b required 1", err);
        end
        inj_q.delete(); inj_t.delete();
        for (int i = 0; i < 5; i++) begin
            pe_tx_valid = 1; pe_tx_data = FW'(32'h300 + i); step(1);
        end
        pe_tx_valid = 0;
        ej_valid = 1; ej_data = 20'h00401; step(1);
        ej_data = 20'h00402; step(1);
        ej_valid = 0;
        step(3);
        checks++;
        if (inj_q.size() != 4) begin
            errors++;
            $display("FAIL overflow_counter_unchanged issued=%0d required 4", inj_q.size());
        end
        RST = 0; step(1); RST = 1;
        ej_cred_cnt = 0;
        checks++;
        if (err !== 1'b0 || pe_rx_valid !== 1'b0 || pe_tx_ready !== 1'b1 || ej_credit !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset err=%b rx_valid=%b tx_ready=%b ej_credit=%b required 0/0/1/0", err, pe_rx_valid, pe_tx_ready, ej_credit);
        end
        pe_rx_ready = 1;
        inj_q.delete(); inj_t.delete();
        for (int i = 0; i < 5; i++) begin
            pe_tx_valid = 1; pe_tx_data = FW'(32'h201 + i); step(1);
        end
        pe_tx_valid = 0;
        step(4);
        pe_rx_ready = 0;
        checks++;
        if (ej_cred_cnt != 0) begin
            errors++;
            $display("FAIL midop_reset_no_credit pulses=%0d required 0", ej_cred_cnt);
        end
        checks++;
        if (inj_q.size() != 4 || inj_q[0] !== 20'h00201 || inj_q[3] !== 20'h00204) begin
            errors++;
            $display("FAIL midop_reset_credits issued=%0d first=%0h required 4 first=201 last=204", inj_q.size(), inj_q.size() > 0 ? inj_q[0] : '0);
        end
    endtask

    task automatic test_stats();
`ifdef NI_STATS_EN
        int pushed;
        int guard;
        RST = 0; step(1); RST = 1;
        inj_q.delete(); inj_t.delete();
        inj_total = 0;
        loopback = 1;
        pushed = 0;
        guard = 0;
        while (pushed < 65537 && guard < 70000) begin
            pe_tx_valid = 1; pe_tx_data = FW'(pushed);
            if (pe_tx_ready) pushed++;
            step(1);
            guard++;
            if (inj_q.size() > 8) begin
                inj_q.delete(); inj_t.delete();
            end
        end
        pe_tx_valid = 0;
        step(6);
        loopback = 0;
        checks++;
        if (inj_total != 65537 || inj_count !== 16'h0001) begin
            errors++;
            $display("FAIL stats_inj_wrap injected=%0d inj_count=%0h required 65537/1", inj_total, inj_count);
        end
        ej_valid = 1; ej_data = 20'h00777; step(1); ej_valid = 0;
        pe_rx_ready = 1; step(1); pe_rx_ready = 0; step(1);
        checks++;
        if (ej_count !== 16'h0001) begin
            errors++;
            $display("FAIL stats_ej_count ej_count=%0h required 1", ej_count);
        end
`else
        checks++;
        if (inj_count !== 16'h0 || ej_count !== 16'h0) begin
            errors++;
            $display("FAIL stats_disabled inj_count=%0h ej_count=%0h required 0", inj_count, ej_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_inject_credits();
        test_credit_return();
        test_credit_same_cycle();
        test_eject();
        test_overflow_and_reset();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_network_interface.md
Name: noc_network_interface

Overview:
Parametrised network interface between a processor element and a router's local (inject/eject) port. It replaces the direct PE-to-router wiring with buffering and credit tracking on both directions.
- Inject side: buffers PE flits and issues them to the router only while downstream credits remain.
- Eject side: buffers router flits and returns one credit per flit consumed by the PE.

Parameters:
FLIT_W, 20, flit width in bits
INJ_DEPTH, 4, inject FIFO entries (power of 2, >=2)
EJ_DEPTH, 4, eject FIFO entries (power of 2, >=2); the router must be initialised with this many credits for the local port
ROUTER_CREDITS, 4, buffer slots in the router's local input port; initial value of the inject credit counter

Ports:
clk  in  1  clock
RST  in  1  synchronous reset, active-low
pe_tx_data  in  FLIT_W  flit from PE
pe_tx_valid  in  1  PE offers flit
pe_tx_ready  out  1  inject FIFO not full
pe_rx_data  out  FLIT_W  flit to PE (head of eject FIFO)
pe_rx_valid  out  1  eject FIFO not empty
pe_rx_ready  in  1  PE accepts flit
inj_data  out  FLIT_W  flit to router local input
inj_valid  out  1  single-cycle flit strobe to router
inj_credit  in  1  credit pulse from router (one slot freed)
ej_data  in  FLIT_W  flit from router local output
ej_valid  in  1  flit strobe from router
ej_credit  out  1  credit pulse to router (one eject slot freed)
err  out  1  sticky protocol error
inj_count  out  16  flits injected (NI_STATS_EN only; otherwise 0)
ej_count  out  16  flits ejected to PE (NI_STATS_EN only; otherwise 0)

Behaviour:
- Reset (RST==0 at posedge clk):
  - Both FIFOs empty.
  - Credit counter = ROUTER_CREDITS.
  - inj_valid=0, inj_data=0, ej_credit=0, err=0, counters=0.
  - pe_tx_ready=1 and pe_rx_valid=0 from the first cycle after reset.
  - Reset mid-operation discards all buffered flits and restores credits; no credit pulses are emitted for discarded flits.
- Inject path:
  - A PE push occurs when pe_tx_valid && pe_tx_ready.
  - pe_tx_ready = !inj_full. It is combinational from FIFO state only and does not depend on pe_tx_valid.
  - Issue condition: inject FIFO not empty && credit>0. When met, the FIFO pops, and inj_data/inj_valid are registered, appearing the next cycle for exactly one cycle. Back-to-back issue every cycle is allowed.
  - PE-to-router latency is 2 cycles when the FIFO is empty and credit>0 (cycle 1: write; cycle 2: issue registered).
  - Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot, but pe_tx_ready is still 0 that cycle).
  - Credit counter (width clog2(ROUTER_CREDITS+1)): -1 on issue, +1 on inj_credit. Both in the same cycle gives no change.
  - If inj_credit arrives while the counter equals ROUTER_CREDITS and there is no same-cycle issue, the increment is ignored and err is set.
- Eject path:
  - ej_valid writes ej_data into the eject FIFO.
  - ej_valid while the FIFO is full and there is no same-cycle PE pop: the flit is dropped and err is set.
  - pe_rx_data/pe_rx_valid are driven combinationally from the FIFO head (first-word-fall-through).
  - A PE pop (pe_rx_valid && pe_rx_ready) produces a registered ej_credit pulse the next cycle, one pulse per pop.
  - Simultaneous write and pop is allowed at any occupancy.
- err: sticky until reset.

Optional Feature:
NI_STATS_EN
- Defined:
  - inj_count increments on each inj_valid cycle.
  - ej_count increments on each PE pop.
  - Both are 16-bit, wrap 0xFFFF->0, and reset to 0.
- Not defined: both ports are tied to 0 and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Package noc_pkg:
  - FLIT_W default (20).
  - POS_W (4), for future source stamping.
  - A clog2 function.
  - Localparam STAT_W=16.
- Sub-module noc_sync_fifo (params WIDTH, DEPTH):
  - Ports: push/pop, FWFT dout, full/empty.
  - Instantiated twice (inject and eject).
- Credit counter, issue register, credit-return register and error logic stay in the top module.

Test Plan:
- Reset, then the PE pushes 0x00001..0x00004 on consecutive cycles with no inj_credit → inj_valid fires 4 times, from cycle 2, with data in order. The counter reaches 0, and a 5th pushed flit stays buffered.
- From the previous state, pulse inj_credit once → exactly one further inj_valid carrying the 5th flit, one cycle after the issue condition is met. The counter returns to 0.
- inj_credit on the same cycle as an issue with credit=1 → the counter stays 1 and the next flit issues the following cycle. err stays 0.
- Router writes 4 flits with pe_rx_ready=0 → pe_rx_valid=1 with pe_rx_data = first flit. A 5th ej_valid sets err and is dropped. Raising pe_rx_ready gives 4 pops in order and 4 ej_credit pulses, each 1 cycle after its pop.
- Extra inj_credit pulse with the counter at ROUTER_CREDITS and idle → err=1, counter unchanged. Assert RST=0 for one cycle → err=0, FIFOs empty, counter=4, no ej_credit pulses.
- With NI_STATS_EN, preload by injecting 65537 flits with inj_credit looped back → inj_count=1 (wrap). Without the macro, both count ports read 0 throughout.
